// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: I2C target over a byte register bank with local port; define I2C_SLAVE_GLITCH_FILTER_EN for 3-sample majority line filtering
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'h3C,
  parameter int NUM_REGS = 16,
  parameter int PW = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          axi_reset_n,
  input  logic          scl_pad_i,
  output logic          scl_pad_o,
  output logic          scl_padoen_o,
  input  logic          sda_pad_i,
  output logic          sda_pad_o,
  output logic          sda_padoen_o,
  input  logic [PW-1:0] loc_addr,
  input  logic [7:0]    loc_wdata,
  input  logic          loc_we,
  output logic [7:0]    loc_rdata,
  output logic          i2c_wr_pulse,
  output logic [PW-1:0] i2c_wr_addr,
  output logic          busy
);
  typedef enum logic [3:0] {IDLE, ADDR, A_ACK, PTR, P_ACK, WDATA, W_ACK, RDATA, R_ACK, WAIT} state_t;
  state_t state, state_d;
  logic [1:0] scl_m, sda_m;
  logic scl_c, sda_c, scl_h, sda_h;
  logic scl_rise, scl_fall, start, stop;
  logic [2:0] cnt, cnt_d;
  logic [6:0] sh, sh_d;
  logic [PW-1:0] ptr, ptr_d;
  logic oe_n, oe_d, rw, rw_d, busy_d, wr_en, match;
  logic [7:0] byte_in, rd;
  logic [7:0] bank [NUM_REGS];
  assign scl_pad_o = 1'b0;
  assign scl_padoen_o = 1'b1;
  assign sda_pad_o = 1'b0;
  assign sda_padoen_o = oe_n;
  always_ff @(posedge clk or negedge axi_reset_n)
    if (!axi_reset_n) begin
      scl_m <= 2'b11;
      sda_m <= 2'b11;
      scl_h <= 1'b1;
      sda_h <= 1'b1;
    end else begin
      scl_m <= {scl_m[0], scl_pad_i};
      sda_m <= {sda_m[0], sda_pad_i};
      scl_h <= scl_c;
      sda_h <= sda_c;
    end
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [2:0] scl_f, sda_f;
  always_ff @(posedge clk or negedge axi_reset_n)
    if (!axi_reset_n) begin
      scl_f <= 3'b111;
      sda_f <= 3'b111;
    end else begin
      scl_f <= {scl_f[1:0], scl_m[1]};
      sda_f <= {sda_f[1:0], sda_m[1]};
    end
  assign scl_c = (scl_f[0] & scl_f[1]) | (scl_f[0] & scl_f[2]) | (scl_f[1] & scl_f[2]);
  assign sda_c = (sda_f[0] & sda_f[1]) | (sda_f[0] & sda_f[2]) | (sda_f[1] & sda_f[2]);
`else
  assign scl_c = scl_m[1];
  assign sda_c = sda_m[1];
`endif
  assign scl_rise = scl_c & ~scl_h;
  assign scl_fall = ~scl_c & scl_h;
  assign start = scl_c & scl_h & sda_h & ~sda_c;
  assign stop = scl_c & scl_h & ~sda_h & sda_c;
  assign byte_in = {sh, sda_c};
  assign match = byte_in[7:1] == SLAVE_ADDR;
  assign rd = bank[ptr];
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    sh_d = sh;
    ptr_d = ptr;
    oe_d = oe_n;
    rw_d = rw;
    busy_d = busy;
    wr_en = 1'b0;
    if (stop) begin
      state_d = IDLE;
      oe_d = 1'b1;
      busy_d = 1'b0;
    end else if (start) begin
      state_d = ADDR;
      cnt_d = 3'd0;
      oe_d = 1'b1;
    end else
      case (state)
        ADDR:
          if (scl_rise) begin
            sh_d = byte_in[6:0];
            cnt_d = cnt + 3'd1;
            if (cnt == 3'd7) begin
              rw_d = byte_in[0];
              busy_d = match;
              state_d = match ? A_ACK : IDLE;
            end
          end
        PTR, WDATA:
          if (scl_rise) begin
            sh_d = byte_in[6:0];
            cnt_d = cnt + 3'd1;
            if (cnt == 3'd7) begin
              state_d = state == PTR ? P_ACK : W_ACK;
              ptr_d = state == PTR ? byte_in[PW-1:0] : ptr + 1'b1;
              wr_en = state == WDATA;
            end
          end
        A_ACK, P_ACK, W_ACK: begin
          if (scl_rise) cnt_d = 3'd1;
          if (scl_fall && cnt == 3'd0) oe_d = 1'b0;
          if (scl_fall && cnt != 3'd0) begin
            cnt_d = 3'd0;
            state_d = state != A_ACK ? WDATA : rw ? RDATA : PTR;
            sh_d = rd[6:0];
            oe_d = !(state == A_ACK && rw) | rd[7];
          end
        end
        RDATA: begin
          if (scl_rise) begin
            cnt_d = cnt + 3'd1;
            if (cnt == 3'd7) begin
              state_d = R_ACK;
              ptr_d = ptr + 1'b1;
            end
          end
          if (scl_fall) begin
            oe_d = sh[6];
            sh_d = {sh[5:0], 1'b0};
          end
        end
        R_ACK: begin
          if (scl_rise) begin
            state_d = sda_c ? WAIT : R_ACK;
            cnt_d = 3'd1;
          end
          if (scl_fall) begin
            oe_d = cnt == 3'd0 | rd[7];
            state_d = cnt == 3'd0 ? R_ACK : RDATA;
            cnt_d = 3'd0;
            sh_d = rd[6:0];
          end
        end
        default: ;
      endcase
  end
  always_ff @(posedge clk or negedge axi_reset_n)
    if (!axi_reset_n) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or negedge axi_reset_n)
    if (!axi_reset_n) begin
      cnt <= '0;
      sh <= '0;
      ptr <= '0;
      oe_n <= 1'b1;
      rw <= 1'b0;
      busy <= 1'b0;
      i2c_wr_pulse <= 1'b0;
      i2c_wr_addr <= '0;
      loc_rdata <= '0;
      for (int i = 0; i < NUM_REGS; i++) bank[i] <= '0;
    end else begin
      cnt <= cnt_d;
      sh <= sh_d;
      ptr <= ptr_d;
      oe_n <= oe_d;
      rw <= rw_d;
      busy <= busy_d;
      i2c_wr_pulse <= wr_en;
      i2c_wr_addr <= wr_en ? ptr : i2c_wr_addr;
      loc_rdata <= bank[loc_addr];
      if (loc_we) bank[loc_addr] <= loc_wdata;
      if (wr_en) bank[ptr] <= byte_in;
    end
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// tb_i2c_slave_regfile: bit-banged I2C master against a transaction-level bank/pointer model
module tb_i2c_slave_regfile;
  localparam int Q = 8;
  logic clk = 1'b0, axi_reset_n = 1'b0, m_scl = 1'b1, m_sda = 1'b1;
  logic scl_pad_i, scl_pad_o, scl_padoen_o, sda_pad_i, sda_pad_o, sda_padoen_o;
  logic [3:0] loc_addr = '0, i2c_wr_addr;
  logic [7:0] loc_wdata = '0, loc_rdata;
  logic loc_we, le = 1'b0, coll_arm = 1'b0, coll_done = 1'b0;
  logic i2c_wr_pulse, busy;
  int n_tests = 0, n_fail = 0, mp = 0;
  logic [7:0] mb [16];
  logic [7:0] txq [$];
  int exp_wq [$];
  logic [3:0] got_wq [$];

  i2c_slave_regfile dut (
    .clk(clk), .axi_reset_n(axi_reset_n),
    .scl_pad_i(scl_pad_i), .scl_pad_o(scl_pad_o), .scl_padoen_o(scl_padoen_o),
    .sda_pad_i(sda_pad_i), .sda_pad_o(sda_pad_o), .sda_padoen_o(sda_padoen_o),
    .loc_addr(loc_addr), .loc_wdata(loc_wdata), .loc_we(loc_we), .loc_rdata(loc_rdata),
    .i2c_wr_pulse(i2c_wr_pulse), .i2c_wr_addr(i2c_wr_addr), .busy(busy)
  );

  always #5 clk = ~clk;
  assign scl_pad_i = m_scl;
  assign sda_pad_i = m_sda & sda_padoen_o;
  assign loc_we = le | (coll_arm & ~coll_done);

  always @(negedge clk) begin
    if (i2c_wr_pulse) got_wq.push_back(i2c_wr_addr);
    coll_done <= coll_arm & (coll_done | i2c_wr_pulse);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic q_wait(input int n);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic bit_io(input logic b, output logic r);
    m_sda = b;
    q_wait(1);
    m_scl = 1'b1;
    q_wait(1);
    r = sda_pad_i;
    q_wait(1);
    m_scl = 1'b0;
    q_wait(1);
  endtask

  task automatic t_start();
    m_sda = 1'b1;
    q_wait(1);
    m_scl = 1'b1;
    q_wait(2);
    m_sda = 1'b0;
    q_wait(2);
    m_scl = 1'b0;
    q_wait(1);
  endtask

  task automatic t_stop();
    m_sda = 1'b0;
    q_wait(1);
    m_scl = 1'b1;
    q_wait(2);
    m_sda = 1'b1;
    q_wait(2);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_io(d[i], r);
    bit_io(1'b1, r);
    ack = !r;
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, r);
      d[i] = r;
    end
    bit_io(nack, r);
  endtask

  task automatic check_pulses(input string tag);
    chk({tag, " pulse count"}, got_wq.size(), exp_wq.size());
    foreach (exp_wq[i])
      if (i < got_wq.size()) chk({tag, " pulse addr"}, got_wq[i], exp_wq[i]);
    got_wq.delete();
    exp_wq.delete();
  endtask

  task automatic i2c_write(input logic [7:0] p, input string tag);
    logic ack;
    t_start();
    send_byte(8'h78, ack);
    chk({tag, " addr ack"}, ack, 1);
    send_byte(p, ack);
    chk({tag, " ptr ack"}, ack, 1);
    mp = p % 16;
    foreach (txq[i]) begin
      send_byte(txq[i], ack);
      chk({tag, " data ack"}, ack, 1);
      mb[mp] = txq[i];
      exp_wq.push_back(mp);
      mp = (mp + 1) % 16;
    end
    t_stop();
    q_wait(1);
    chk({tag, " busy idle"}, busy, 0);
    check_pulses(tag);
  endtask

  task automatic i2c_read(input int n, input logic set_ptr, input logic [7:0] p, input string tag);
    logic ack;
    logic [7:0] d;
    t_start();
    if (set_ptr) begin
      send_byte(8'h78, ack);
      chk({tag, " w addr ack"}, ack, 1);
      send_byte(p, ack);
      chk({tag, " ptr ack"}, ack, 1);
      mp = p % 16;
      t_start();
    end
    send_byte(8'h79, ack);
    chk({tag, " r addr ack"}, ack, 1);
    chk({tag, " busy"}, busy, 1);
    for (int i = 0; i < n; i++) begin
      recv_byte(i == n - 1, d);
      chk({tag, " rdata"}, d, mb[mp]);
      mp = (mp + 1) % 16;
    end
    t_stop();
    q_wait(1);
    chk({tag, " busy idle"}, busy, 0);
    chk({tag, " sda released"}, sda_padoen_o, 1);
  endtask

  task automatic loc_read(input int a, output logic [7:0] d);
    loc_addr = a[3:0];
    @(negedge clk);
    d = loc_rdata;
  endtask

  task automatic loc_write(input int a, input logic [7:0] d);
    loc_addr = a[3:0];
    loc_wdata = d;
    le = 1'b1;
    @(negedge clk);
    le = 1'b0;
    mb[a] = d;
  endtask

  task automatic collide(input logic [3:0] p, input logic [3:0] la, input logic [7:0] lw, input logic [7:0] d);
    logic ack;
    logic [7:0] r;
    t_start();
    send_byte(8'h78, ack);
    send_byte({4'h0, p}, ack);
    loc_addr = la;
    loc_wdata = lw;
    coll_arm = 1'b1;
    send_byte(d, ack);
    coll_arm = 1'b0;
    chk("coll data ack", ack, 1);
    t_stop();
    mb[la] = lw;
    mb[p] = d;
    exp_wq.push_back(p);
    mp = (p + 1) % 16;
    check_pulses("coll");
    loc_read(p, r);
    chk("coll i2c reg", r, mb[p]);
    loc_read(la, r);
    chk("coll loc reg", r, mb[la]);
  endtask

  initial begin
    logic ack, r;
    logic [7:0] d;
    foreach (mb[i]) mb[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst sda_padoen", sda_padoen_o, 1);
    chk("rst loc_rdata", loc_rdata, 0);
    chk("rst wr_pulse", i2c_wr_pulse, 0);
    chk("rst wr_addr", i2c_wr_addr, 0);
    chk("rst busy", busy, 0);
    chk("const pads", {scl_pad_o, scl_padoen_o, sda_pad_o}, 3'b010);
    axi_reset_n = 1'b1;
    q_wait(1);
    txq = '{8'hA5, 8'h5A};
    i2c_write(8'h02, "t1");
    i2c_read(2, 1'b1, 8'h02, "t2");
    t_start();
    send_byte(8'h7A, ack);
    chk("t3 nack", ack, 0);
    chk("t3 busy", busy, 0);
    t_stop();
    q_wait(1);
    check_pulses("t3");
    txq = '{8'h11, 8'h22};
    i2c_write(8'h0F, "t4");
    loc_read(15, d);
    chk("t4 reg15", d, 8'h11);
    loc_read(0, d);
    chk("t4 reg0", d, 8'h22);
    collide(4'd3, 4'd3, 8'h77, 8'h99);
    chk("t5 reg3", mb[3], 8'h99);
    collide(4'd4, 4'd5, 8'($urandom), 8'($urandom));
    t_start();
    send_byte(8'h78, ack);
    send_byte(8'h06, ack);
    mp = 6;
    for (int i = 0; i < 4; i++) bit_io(i[0], r);
    t_stop();
    q_wait(1);
    chk("abort busy", busy, 0);
    chk("abort sda released", sda_padoen_o, 1);
    check_pulses("abort");
    i2c_read(1, 1'b0, 8'h00, "abort ptr kept");
    for (int k = 0; k < 6; k++) begin
      txq.delete();
      repeat ($urandom_range(1, 4)) txq.push_back(8'($urandom));
      i2c_write(8'($urandom), "rnd wr");
      loc_write($urandom_range(0, 15), 8'($urandom));
      i2c_read($urandom_range(1, 5), 1'($urandom), 8'($urandom), "rnd rd");
    end
    t_start();
    for (int i = 7; i >= 0; i--) bit_io(i == 0 ? 1'b0 : 1'(8'h78 >> i), r);
    m_sda = 1'b1;
    q_wait(1);
    chk("t6 ack driven", sda_padoen_o, 0);
    axi_reset_n = 1'b0;
    #1;
    chk("t6 async release", sda_padoen_o, 1);
    @(negedge clk);
    m_scl = 1'b1;
    repeat (2) @(negedge clk);
    axi_reset_n = 1'b1;
    q_wait(2);
    foreach (mb[i]) mb[i] = 8'h00;
    mp = 0;
    got_wq.delete();
    exp_wq.delete();
    chk("t6 busy after reset", busy, 0);
    txq = '{8'($urandom), 8'($urandom), 8'($urandom)};
    i2c_write(8'($urandom_range(0, 15)), "t6 wr");
    for (int a = 0; a < 16; a++) begin
      loc_read(a, d);
      chk("final bank", d, mb[a]);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
